paralelo_serial_ctrl: RTL and testbench
=======================================

PARALELO_SERIAL_CTRL -- requirements
Module: paralelo_serial_ctrl

Interface
REQ-001 Parameter TRAIN_LEN, default 4, SHALL set the number of consecutive COM_SYM bytes sent in TRAIN before entering ACTIVE.
REQ-002 Parameter SKP_INTERVAL, default 16, SHALL set the ACTIVE-state period, in cycles, of forced SKP_SYM insertion; legal range 2..256.
REQ-003 Parameters COM_SYM 8'hBC, IDL_SYM 8'h7C, SKP_SYM 8'h1C SHALL be the training, idle and skip symbols.
REQ-004 clk_4f  input  1  byte clock, the single clock; all state changes on its rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  link enable; 1 requests training and then ACTIVE, 0 forces IDLE.
REQ-007 data_in  input  8  upstream data byte.
REQ-008 valid_in  input  1  data_in holds a byte to send.
REQ-009 ready_out  output  1  controller accepts data_in this cycle; combinational from registered state and enable.
REQ-010 byte_out  output  8  registered byte to the serializer.
REQ-011 byte_valid  output  1  registered; byte_out carries upstream data.
REQ-012 active  output  1  registered serializer mode select; 1 when byte_out was produced in ACTIVE.
REQ-013 tx_count  output  16  registered count of accepted data bytes.

Function
REQ-014 States SHALL be IDLE, TRAIN and ACTIVE, held in a registered state variable.
REQ-015 IDLE->TRAIN SHALL occur on enable=1; TRAIN->ACTIVE SHALL occur on the edge ending the TRAIN_LEN-th TRAIN cycle; any state->IDLE SHALL occur on an edge with enable=0.
REQ-016 The TRAIN counter SHALL clear on entry to TRAIN and whenever TRAIN is left, so re-training always sends a full TRAIN_LEN bytes.
REQ-017 skp_cnt SHALL count ACTIVE cycles from 0 to SKP_INTERVAL-1 and wrap to 0; it SHALL clear whenever the state is not ACTIVE.
REQ-018 A cycle is a skip slot when state=ACTIVE and skp_cnt=SKP_INTERVAL-1.
REQ-019 ready_out SHALL be 1 only when state=ACTIVE, enable=1 and the cycle is not a skip slot.
REQ-020 A transfer SHALL occur when valid_in=1 and ready_out=1; no byte is accepted otherwise, and data_in is ignored.
REQ-021 Output registers SHALL load on each edge from the current state:
- IDLE: byte_out=IDL_SYM, byte_valid=0, active=0.
- TRAIN: byte_out=COM_SYM, byte_valid=0, active=0.
- ACTIVE skip slot: byte_out=SKP_SYM, byte_valid=0, active=1.
- ACTIVE transfer: byte_out=data_in, byte_valid=1, active=1.
- ACTIVE otherwise: byte_out=IDL_SYM, byte_valid=0, active=1.
REQ-022 Latency from an accepted byte to its appearance on byte_out SHALL be exactly 1 cycle; byte order SHALL be preserved.
REQ-023 ACTIVE with enable=0 SHALL accept no byte, emit IDL_SYM with active=1 for that cycle, then enter IDLE.
REQ-024 tx_count SHALL increment by 1 per transfer, wrap from 16'hFFFF to 0, and hold its value across IDLE and re-training.
REQ-025 No skip slot SHALL be dropped or deferred by pending valid_in; the upstream waits.

Reset
REQ-026 reset_L=0 SHALL asynchronously set state=IDLE, the TRAIN counter=0, skp_cnt=0, byte_out=8'h00, byte_valid=0, active=0 and tx_count=0; ready_out is therefore 0.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight byte; after release, operation SHALL restart from IDLE.

Verification
REQ-028 After reset release with enable=1: byte_out sequence IDL, BC, BC, BC, BC, then 7C with active=1; ready_out rises in the first ACTIVE cycle.
REQ-029 ACTIVE, valid_in held 1, data 0x01,0x02,...: each byte appears 1 cycle later with byte_valid=1; ready_out=0 once per 16 cycles; 0x1C is emitted in that slot; no byte is lost or duplicated; tx_count=15 after 16 cycles.
REQ-030 enable dropped after 2 TRAIN cycles, then reasserted: IDLE emits 7C; the re-train emits 4 full BC bytes before ACTIVE.
REQ-031 enable dropped in ACTIVE with valid_in=1: ready_out=0 that cycle, byte_out=7C with active=1, then active=0 and byte_out=7C.
REQ-032 tx_count preloaded to 16'hFFFF via 65535 transfers; one more transfer -> tx_count=0.
REQ-033 reset_L pulsed low mid-ACTIVE between clock edges: outputs clear immediately to 00/0/0/0; after release, the REQ-028 sequence repeats.

Source files
------------

// File: rtl/paralelo_serial_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// paralelo_serial_ctrl_if : upstream/serializer bundle of the link ctrl
// Rev 1.0
// ------------------------------------------------------------------
interface paralelo_serial_ctrl_if;
  logic        enable;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        active;
  logic [15:0] tx_count;

  modport master (
    output enable, data_in, valid_in,
    input  ready_out, byte_out, byte_valid, active, tx_count
  );

  modport slave (
    input  enable, data_in, valid_in,
    output ready_out, byte_out, byte_valid, active, tx_count
  );
endinterface
`default_nettype wire

// File: rtl/paralelo_serial_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// paralelo_serial_ctrl : IDLE/TRAIN/ACTIVE link controller feeding a
//   byte serializer, with periodic SKP insertion while ACTIVE.
// Rev 1.0
// ------------------------------------------------------------------
module paralelo_serial_ctrl #(
  parameter int unsigned TRAIN_LEN    = 4,
  parameter int unsigned SKP_INTERVAL = 16,
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter logic [7:0]  IDL_SYM      = 8'h7C,
  parameter logic [7:0]  SKP_SYM      = 8'h1C
) (
  input logic                   clk_4f,
  input logic                   reset_L,
  paralelo_serial_ctrl_if.slave bus
);

  localparam int unsigned TRAIN_W = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam int unsigned SKP_W   = $clog2(SKP_INTERVAL);

  localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(TRAIN_LEN - 1);
  localparam logic [SKP_W-1:0]   SKP_LAST   = SKP_W'(SKP_INTERVAL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAIN  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t             state_q;
  logic [TRAIN_W-1:0] train_cnt_q;
  logic [SKP_W-1:0]   skp_cnt_q;
  logic [7:0]         byte_out_q;
  logic               byte_valid_q;
  logic               active_q;
  logic [15:0]        tx_count_q;

  logic skip_slot;
  logic ready;
  logic xfer;

  assign skip_slot = (state_q == S_ACTIVE) && (skp_cnt_q == SKP_LAST);
  assign ready     = (state_q == S_ACTIVE) && bus.enable && !skip_slot;
  assign xfer      = ready && bus.valid_in;

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= S_IDLE;
      train_cnt_q  <= '0;
      skp_cnt_q    <= '0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      active_q     <= 1'b0;
      tx_count_q   <= 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          byte_out_q   <= IDL_SYM;
          byte_valid_q <= 1'b0;
          active_q     <= 1'b0;
          train_cnt_q  <= '0;
          skp_cnt_q    <= '0;
          if (bus.enable) begin
            state_q <= S_TRAIN;
          end
        end

        S_TRAIN: begin
          byte_out_q   <= COM_SYM;
          byte_valid_q <= 1'b0;
          active_q     <= 1'b0;
          skp_cnt_q    <= '0;
          if (!bus.enable) begin
            state_q     <= S_IDLE;
            train_cnt_q <= '0;
          end else if (train_cnt_q == TRAIN_LAST) begin
            state_q     <= S_ACTIVE;
            train_cnt_q <= '0;
          end else begin
            train_cnt_q <= train_cnt_q + TRAIN_W'(1);
          end
        end

        S_ACTIVE: begin
          active_q    <= 1'b1;
          train_cnt_q <= '0;
          // A link being torn down sends idle, even on a skip slot.
          if (!bus.enable) begin
            byte_out_q   <= IDL_SYM;
            byte_valid_q <= 1'b0;
            state_q      <= S_IDLE;
            skp_cnt_q    <= '0;
          end else begin
            if (skip_slot) begin
              byte_out_q   <= SKP_SYM;
              byte_valid_q <= 1'b0;
            end else if (xfer) begin
              byte_out_q   <= bus.data_in;
              byte_valid_q <= 1'b1;
              tx_count_q   <= tx_count_q + 16'd1;
            end else begin
              byte_out_q   <= IDL_SYM;
              byte_valid_q <= 1'b0;
            end
            skp_cnt_q <= (skp_cnt_q == SKP_LAST) ? '0 : skp_cnt_q + SKP_W'(1);
          end
        end

        default: begin
          state_q      <= S_IDLE;
          train_cnt_q  <= '0;
          skp_cnt_q    <= '0;
          byte_out_q   <= IDL_SYM;
          byte_valid_q <= 1'b0;
          active_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out  = ready;
  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.active     = active_q;
  assign bus.tx_count   = tx_count_q;

endmodule
`default_nettype wire

// File: tb/tb_paralelo_serial_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_paralelo_serial_ctrl : directed + random bench with a cycle model
// Rev 1.0
// ------------------------------------------------------------------
module tb_paralelo_serial_ctrl;

  localparam int TRAIN_LEN = 4;
  localparam int SKP       = 16;

  logic clk_4f  = 1'b0;
  logic reset_L = 1'b0;

  paralelo_serial_ctrl_if bus ();

  paralelo_serial_ctrl #(
    .TRAIN_LEN    (TRAIN_LEN),
    .SKP_INTERVAL (SKP)
  ) dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_4f = ~clk_4f;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: link mode, BC bytes sent, ACTIVE cycles since entry
  int          m_mode;
  int          m_trained;
  int          m_acnt;
  logic [15:0] m_tx;
  logic [7:0]  m_byte;
  logic        m_bv;
  logic        m_act;
  logic [7:0]  m_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_trained = 0; m_acnt = 0; m_tx = 16'h0000;
    m_byte = 8'h00; m_bv = 1'b0; m_act = 1'b0;
    m_q.delete();
  endtask

  function automatic bit model_slot();
    return (m_mode == 2) && ((m_acnt % SKP) == SKP - 1);
  endfunction

  function automatic bit model_ready(input logic en);
    return (m_mode == 2) && en && !model_slot();
  endfunction

  task automatic model_step(input logic en, input logic vin, input logic [7:0] din);
    bit slot;
    bit take;
    slot = model_slot();
    take = model_ready(en) && vin;
    if (take) m_q.push_back(din);
    m_bv = 1'b0;
    case (m_mode)
      0: begin
        m_byte = 8'h7C; m_act = 1'b0;
        if (en) begin m_mode = 1; m_trained = 0; end
      end
      1: begin
        m_byte = 8'hBC; m_act = 1'b0;
        m_trained++;
        if (!en) m_mode = 0;
        else if (m_trained == TRAIN_LEN) begin m_mode = 2; m_acnt = 0; end
      end
      default: begin
        m_act = 1'b1;
        if (!en) begin
          m_byte = 8'h7C; m_mode = 0;
        end else begin
          if (slot) m_byte = 8'h1C;
          else if (take) begin
            m_byte = m_q.pop_front(); m_bv = 1'b1; m_tx = m_tx + 16'd1;
          end else m_byte = 8'h7C;
          m_acnt++;
        end
      end
    endcase
  endtask

  // Entered and left one tick past a rising edge.
  task automatic tick(input logic en, input logic vin, input logic [7:0] din);
    bus.enable = en; bus.valid_in = vin; bus.data_in = din;
    #1;
    chk("ready_out", 16'(bus.ready_out), 16'(model_ready(en)));
    @(posedge clk_4f);
    model_step(en, vin, din);
    #1;
    chk("byte_out",   16'(bus.byte_out),   16'(m_byte));
    chk("byte_valid", 16'(bus.byte_valid), 16'(m_bv));
    chk("active",     16'(bus.active),     16'(m_act));
    chk("tx_count",   bus.tx_count,        m_tx);
  endtask

  task automatic bringup_check(input string tag);
    logic [7:0] seq [6];
    seq = '{8'h7C, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h7C};
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, 8'h00);
      chk(tag, 16'(bus.byte_out), 16'(seq[i]));
      chk({tag, "_act"}, 16'(bus.active), (i == 5) ? 16'd1 : 16'd0);
    end
  endtask

  task automatic leave_slot();
    int guard = 0;
    while (!model_ready(1'b1) && guard < 2 * SKP) begin
      tick(1'b1, 1'b0, 8'h00);
      guard++;
    end
  endtask

  initial begin
    int bc;
    int guard;
    logic [7:0] d;

    bus.enable = 1'b0; bus.valid_in = 1'b0; bus.data_in = 8'h00;
    model_reset();
    @(posedge clk_4f);
    #1;
    chk("rst_byte_out",   16'(bus.byte_out),   16'h0000);
    chk("rst_byte_valid", 16'(bus.byte_valid), 16'h0000);
    chk("rst_active",     16'(bus.active),     16'h0000);
    chk("rst_tx_count",   bus.tx_count,        16'h0000);
    chk("rst_ready",      16'(bus.ready_out),  16'h0000);
    reset_L = 1'b1;

    bringup_check("bringup_seq");

    // Continuous stream: byte order, skip slot every SKP cycles
    d = 8'h01;
    for (int i = 0; i < 3 * SKP; i++) begin
      tick(1'b1, 1'b1, d);
      if (bus.byte_valid) d = d + 8'd1;
    end

    for (int i = 0; i < 200; i++)
      tick(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));

    // Drop enable in ACTIVE with data pending, then mid-TRAIN drop and retrain
    leave_slot();
    tick(1'b0, 1'b1, 8'hA5);
    chk("drop_act_byte", 16'(bus.byte_out), 16'h007C);
    chk("drop_act_flag", 16'(bus.active),   16'h0001);
    tick(1'b0, 1'b1, 8'h5A);
    chk("idle_byte", 16'(bus.byte_out), 16'h007C);
    chk("idle_act",  16'(bus.active),   16'h0000);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    chk("idle_after_train", 16'(bus.byte_out), 16'h007C);
    bc = 0;
    guard = 0;
    while (!bus.active && guard < 12) begin
      tick(1'b1, 1'b0, 8'h00);
      if (bus.byte_out == 8'hBC) bc++;
      guard++;
    end
    chk("retrain_bc", 16'(bc), 16'd4);

    for (int i = 0; i < 100; i++)
      tick(1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom));

    // Counter wrap
    guard = 0;
    while (m_tx != 16'hFFFF && guard < 80000) begin
      tick(1'b1, 1'b1, 8'($urandom));
      guard++;
    end
    chk("tx_at_ffff", bus.tx_count, 16'hFFFF);
    guard = 0;
    while (m_tx != 16'h0000 && guard < 2 * SKP) begin
      tick(1'b1, 1'b1, 8'($urandom));
      guard++;
    end
    chk("tx_wrap", bus.tx_count, 16'h0000);

    // Asynchronous reset pulse between edges
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 8'($urandom));
    reset_L = 1'b0;
    #1;
    chk("arst_byte_out",   16'(bus.byte_out),   16'h0000);
    chk("arst_byte_valid", 16'(bus.byte_valid), 16'h0000);
    chk("arst_active",     16'(bus.active),     16'h0000);
    chk("arst_tx_count",   bus.tx_count,        16'h0000);
    chk("arst_ready",      16'(bus.ready_out),  16'h0000);
    model_reset();
    #1;
    reset_L = 1'b1;
    bringup_check("rebringup_seq");
    for (int i = 0; i < 40; i++)
      tick(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
